// File: rtl/demux_pkg.sv
// Shared lane constants and the select-to-one-hot decode used by the demux
// datapath and its register stage.
package demux_pkg;

   localparam logic [1:0] LANE_A = 2'd0;
   localparam logic [1:0] LANE_B = 2'd1;
   localparam logic [1:0] LANE_C = 2'd2;
   localparam logic [1:0] LANE_D = 2'd3;

   // Any select that is not a clean lane index decodes to no lane at all.
   function automatic logic [3:0] onehot4(input logic [1:0] sel);
      logic [3:0] oh;
      oh = 4'b0000;
      case (sel)
         LANE_A:  oh = 4'b0001;
         LANE_B:  oh = 4'b0010;
         LANE_C:  oh = 4'b0100;
         LANE_D:  oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux4_comb.sv
// Combinational 1:4 steering of f onto one lane, with the lane one-hot.
module demux4_comb
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] f,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] c_o,
   output logic [WIDTH-1:0] d_o,
   output logic [3:0]       oh_o
);

   always_comb begin
      oh_o = onehot4(sel);
      a_o  = oh_o[0] ? f : '0;
      b_o  = oh_o[1] ? f : '0;
      c_o  = oh_o[2] ? f : '0;
      d_o  = oh_o[3] ? f : '0;
   end

endmodule

// File: rtl/demux4_reg.sv
// Registered 1:4 lane demux: one cycle of latency, capture enable, optional
// hold of unselected lanes, synchronous clear.
module demux4_reg
   import demux_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter bit HOLD_UNSEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] f,
   input  logic [1:0]       sel,
   input  logic             en,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [1:0]       sel_q,
   output logic [3:0]       vld
);

   logic [WIDTH-1:0] lane_a, lane_b, lane_c, lane_d;
   logic [3:0]       lane_oh;

   logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
   logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
   logic [1:0]       sel_cap_d, sel_cap_q;
   logic [3:0]       vld_d, vld_q;

   demux4_comb #(.WIDTH(WIDTH)) u_comb (
      .f    (f),
      .sel  (sel),
      .a_o  (lane_a),
      .b_o  (lane_b),
      .c_o  (lane_c),
      .d_o  (lane_d),
      .oh_o (lane_oh)
   );

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      sel_cap_d = sel_cap_q;
      vld_d     = 4'b0000;
      if (en) begin
         // Re-encode from the one-hot so an invalid select captures as lane A.
         sel_cap_d = {lane_oh[3] | lane_oh[2], lane_oh[3] | lane_oh[1]};
         vld_d     = lane_oh;
         a_d       = (HOLD_UNSEL && !lane_oh[0]) ? a_q : lane_a;
         b_d       = (HOLD_UNSEL && !lane_oh[1]) ? b_q : lane_b;
         c_d       = (HOLD_UNSEL && !lane_oh[2]) ? c_q : lane_c;
         d_d       = (HOLD_UNSEL && !lane_oh[3]) ? d_q : lane_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         sel_cap_q <= LANE_A;
         vld_q     <= 4'b0000;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         d_q       <= d_d;
         sel_cap_q <= sel_cap_d;
         vld_q     <= vld_d;
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign c     = c_q;
   assign d     = d_q;
   assign sel_q = sel_cap_q;
   assign vld   = vld_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Bench for demux4_reg: three configurations share one stimulus stream; each
// directed vector carries hand-computed outputs for the configuration it targets.
module tb_demux4_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [1:0] sel = 2'b00;
   logic [7:0] f   = 8'h00;

   always #5 clk = ~clk;

   // id 0: WIDTH=1 HOLD_UNSEL=0
   logic [0:0] a0, b0, c0, d0;
   logic [1:0] sq0;
   logic [3:0] v0;
   // id 1: WIDTH=8 HOLD_UNSEL=1
   logic [7:0] a1, b1, c1, d1;
   logic [1:0] sq1;
   logic [3:0] v1;
   // id 2: WIDTH=8 HOLD_UNSEL=0
   logic [7:0] a2, b2, c2, d2;
   logic [1:0] sq2;
   logic [3:0] v2;

   demux4_reg #(.WIDTH(1), .HOLD_UNSEL(1'b0)) u_w1 (
      .clk(clk), .rst(rst), .f(f[0:0]), .sel(sel), .en(en),
      .a(a0), .b(b0), .c(c0), .d(d0), .sel_q(sq0), .vld(v0)
   );

   demux4_reg #(.WIDTH(8), .HOLD_UNSEL(1'b1)) u_hold (
      .clk(clk), .rst(rst), .f(f), .sel(sel), .en(en),
      .a(a1), .b(b1), .c(c1), .d(d1), .sel_q(sq1), .vld(v1)
   );

   demux4_reg #(.WIDTH(8), .HOLD_UNSEL(1'b0)) u_zero (
      .clk(clk), .rst(rst), .f(f), .sel(sel), .en(en),
      .a(a2), .b(b2), .c(c2), .d(d2), .sel_q(sq2), .vld(v2)
   );

   typedef struct {
      string      nm;
      int         id;
      logic [7:0] a, b, c, d;
      logic [1:0] sq;
      logic [3:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Monitor: outputs are presented once per cycle; pop and compare at negedge.
   exp_t       e;
   logic [7:0] ga, gb, gc, gd;
   logic [1:0] gsq;
   logic [3:0] gv;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.id)
            0: begin
               ga = {7'd0, a0}; gb = {7'd0, b0}; gc = {7'd0, c0}; gd = {7'd0, d0};
               gsq = sq0; gv = v0;
            end
            1: begin
               ga = a1; gb = b1; gc = c1; gd = d1; gsq = sq1; gv = v1;
            end
            default: begin
               ga = a2; gb = b2; gc = c2; gd = d2; gsq = sq2; gv = v2;
            end
         endcase
         n_checks++;
         if (ga !== e.a || gb !== e.b || gc !== e.c || gd !== e.d ||
             gsq !== e.sq || gv !== e.v) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got a=%h b=%h c=%h d=%h sel_q=%b vld=%b, expected a=%h b=%h c=%h d=%h sel_q=%b vld=%b",
                     e.nm, e.id, ga, gb, gc, gd, gsq, gv, e.a, e.b, e.c, e.d, e.sq, e.v);
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic en_i,
                       input logic [1:0] sel_i, input logic [7:0] f_i, input int id,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input logic [7:0] ed,
                       input logic [1:0] esq, input logic [3:0] ev);
      exp_t x;
      @(negedge clk);
      #1;
      rst = r;
      en  = en_i;
      sel = sel_i;
      f   = f_i;
      x.nm = nm; x.id = id;
      x.a = ea; x.b = eb; x.c = ec; x.d = ed; x.sq = esq; x.v = ev;
      exp_q.push_back(x);
   endtask

   initial begin
      // WIDTH=1, HOLD_UNSEL=0: reset, exhaustive sweep, enable hold
      step("w1_rst0", 1, 1, 2'b10, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("w1_rst1", 1, 1, 2'b10, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("w1_f0s0", 0, 1, 2'b00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0001);
      step("w1_f0s1", 0, 1, 2'b01, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 4'b0010);
      step("w1_f0s2", 0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 4'b0100);
      step("w1_f0s3", 0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 4'b1000);
      step("w1_f1s0", 0, 1, 2'b00, 8'h01, 0, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0001);
      step("w1_f1s1", 0, 1, 2'b01, 8'h01, 0, 8'h00, 8'h01, 8'h00, 8'h00, 2'b01, 4'b0010);
      step("w1_f1s2", 0, 1, 2'b10, 8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h00, 2'b10, 4'b0100);
      step("w1_f1s3", 0, 1, 2'b11, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 4'b1000);
      step("w1_hold0", 0, 0, 2'b00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 4'b0000);
      step("w1_hold1", 0, 0, 2'b00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 4'b0000);
      step("w1_hold2", 0, 0, 2'b00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 4'b0000);

      // WIDTH=8, HOLD_UNSEL=1: unselected lanes keep their value
      step("hd_rst",   1, 1, 2'b01, 8'h77, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("hd_a5",    0, 1, 2'b00, 8'hA5, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0001);
      step("hd_3c",    0, 1, 2'b10, 8'h3C, 1, 8'hA5, 8'h00, 8'h3C, 8'h00, 2'b10, 4'b0100);
      step("hd_en0",   0, 0, 2'b11, 8'hFF, 1, 8'hA5, 8'h00, 8'h3C, 8'h00, 2'b10, 4'b0000);
      step("hd_d11",   0, 1, 2'b11, 8'h11, 1, 8'hA5, 8'h00, 8'h3C, 8'h11, 2'b11, 4'b1000);
      step("hd_a5a",   0, 1, 2'b00, 8'h5A, 1, 8'h5A, 8'h00, 8'h3C, 8'h11, 2'b00, 4'b0001);

      // WIDTH=8, HOLD_UNSEL=0: lane walk, mid-stream reset, enable after reset
      step("zr_rst",   1, 1, 2'b11, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("zr_walk0", 0, 1, 2'b00, 8'hFF, 2, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0001);
      step("zr_walk1", 0, 1, 2'b01, 8'hFF, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b01, 4'b0010);
      step("zr_walk2", 0, 1, 2'b10, 8'hFF, 2, 8'h00, 8'h00, 8'hFF, 8'h00, 2'b10, 4'b0100);
      step("zr_walk3", 0, 1, 2'b11, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'hFF, 2'b11, 4'b1000);
      step("zr_midrst",1, 1, 2'b01, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("zr_postb", 0, 1, 2'b01, 8'hFF, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b01, 4'b0010);
      step("zr_rsten0",1, 0, 2'b10, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("zr_idle",  0, 0, 2'b10, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000);
      step("zr_c42",   0, 1, 2'b10, 8'h42, 2, 8'h00, 8'h00, 8'h42, 8'h00, 2'b10, 4'b0100);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
